// File: rtl/encoder_4to2_serial.sv
// Serialising 4-to-2 priority encoder: captures a request vector and emits
// one code beat per set bit. Optional macro ENC_EMPTY_FLAG_EN adds an empty-vector beat.
module encoder_4to2_serial #(
  parameter int HIGH_FIRST = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [3:0] req,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [1:0] code,
  output logic       last,
  output logic       empty
);

  typedef enum logic {
    S_IDLE,
    S_EMIT
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] pend_q, pend_d;
  logic       empty_q, empty_d;
  logic       in_ready_q, out_valid_q, last_q;
  logic [1:0] code_q;

  // Index of the set bit that has priority for the next beat.
  function automatic logic [1:0] pick(input logic [3:0] v);
    pick = 2'd0;
    if (HIGH_FIRST != 0) begin
      for (int i = 0; i < 4; i++)
        if (v[i]) pick = 2'(i);
    end else begin
      for (int i = 3; i >= 0; i--)
        if (v[i]) pick = 2'(i);
    end
  endfunction

  function automatic logic single(input logic [3:0] v);
    single = (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
  endfunction

  always_comb begin
    // NOTE: every signal gets a default first so no path can infer a latch.
    state_d = state_q;
    pend_d  = pend_q;
    empty_d = empty_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          pend_d = req;
          if (req != 4'd0) begin
            state_d = S_EMIT;
            empty_d = 1'b0;
          end else begin
`ifdef ENC_EMPTY_FLAG_EN
            state_d = S_EMIT;
            empty_d = 1'b1;
`endif
          end
        end
      end
      S_EMIT: begin
        if (out_ready) begin
          if (empty_q || single(pend_q)) begin
            state_d = S_IDLE;
            pend_d  = 4'd0;
            empty_d = 1'b0;
          end else begin
            pend_d = pend_q & ~(4'b0001 << pick(pend_q));
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are registered from next-state so they change only on clock edges.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (rst) begin
      state_q     <= S_IDLE;
      pend_q      <= 4'd0;
      empty_q     <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      code_q      <= 2'd0;
      last_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      pend_q      <= pend_d;
      empty_q     <= empty_d;
      in_ready_q  <= (state_d == S_IDLE);
      out_valid_q <= (state_d == S_EMIT);
      code_q      <= (state_d == S_EMIT && !empty_d) ? pick(pend_d) : 2'd0;
      last_q      <= (state_d == S_EMIT) && (empty_d || single(pend_d));
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign code      = code_q;
  assign last      = last_q;
`ifdef ENC_EMPTY_FLAG_EN
  assign empty     = empty_q;
`else
  assign empty     = 1'b0;
`endif

endmodule

// File: tb/tb_encoder_4to2_serial.sv
// Bench for encoder_4to2_serial: directed cycle table, hand sequences and
// random traffic, with both priority orders instantiated side by side.
module tb_encoder_4to2_serial;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic [3:0] req = 4'd0;
  logic       out_ready = 1'b0;

  logic       lo_in_ready, lo_out_valid, lo_last, lo_empty;
  logic [1:0] lo_code;
  logic       hi_in_ready, hi_out_valid, hi_last, hi_empty;
  logic [1:0] hi_code;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  encoder_4to2_serial #(.HIGH_FIRST(0)) dut_lo (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(lo_in_ready), .req(req),
    .out_valid(lo_out_valid), .out_ready(out_ready), .code(lo_code),
    .last(lo_last), .empty(lo_empty)
  );

  encoder_4to2_serial #(.HIGH_FIRST(1)) dut_hi (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(hi_in_ready), .req(req),
    .out_valid(hi_out_valid), .out_ready(out_ready), .code(hi_code),
    .last(hi_last), .empty(hi_empty)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: pending beats as lists of indices in emission order.
  int exp_lo[$];
  int exp_hi[$];
  bit exp_empty_beat = 1'b0;

  function automatic bit model_valid();
    return (exp_lo.size() > 0) || exp_empty_beat;
  endfunction

  task automatic model_edge(input bit rs, input bit iv, input logic [3:0] r, input bit ordy);
    if (rs) begin
      exp_lo.delete();
      exp_hi.delete();
      exp_empty_beat = 1'b0;
    end else if (model_valid()) begin
      if (ordy) begin
        if (exp_empty_beat) exp_empty_beat = 1'b0;
        else begin
          void'(exp_lo.pop_front());
          void'(exp_hi.pop_front());
        end
      end
    end else if (iv) begin
      for (int i = 0; i < 4; i++) if (r[i]) exp_lo.push_back(i);
      for (int i = 3; i >= 0; i--) if (r[i]) exp_hi.push_back(i);
`ifdef ENC_EMPTY_FLAG_EN
      if (r == 4'd0) exp_empty_beat = 1'b1;
`endif
    end
  endtask

  task automatic check_model(input string tag);
    bit v;
    int lo_c, hi_c;
    bit l;
    v    = model_valid();
    lo_c = (exp_lo.size() > 0) ? exp_lo[0] : 0;
    hi_c = (exp_hi.size() > 0) ? exp_hi[0] : 0;
    l    = exp_empty_beat || (exp_lo.size() == 1);
    check({tag, " lo out_valid"}, 32'(lo_out_valid), 32'(v));
    check({tag, " lo in_ready"},  32'(lo_in_ready),  32'(!v));
    check({tag, " lo code"},      32'(lo_code),      32'(lo_c));
    check({tag, " lo last"},      32'(lo_last),      32'(l));
    check({tag, " lo empty"},     32'(lo_empty),     32'(exp_empty_beat));
    check({tag, " hi out_valid"}, 32'(hi_out_valid), 32'(v));
    check({tag, " hi code"},      32'(hi_code),      32'(hi_c));
    check({tag, " hi last"},      32'(hi_last),      32'(l));
  endtask

  // Drive one cycle of inputs from the falling edge, then sample at the next one.
  task automatic cycle(input string tag, input bit rs, input bit iv, input logic [3:0] r, input bit ordy);
    rst = rs; in_valid = iv; req = r; out_ready = ordy;
    @(posedge clk);
    model_edge(rs, iv, r, ordy);
    @(negedge clk);
    check_model(tag);
  endtask

  typedef struct {
    bit         rs;
    bit         iv;
    logic [3:0] r;
    bit         ordy;
    bit         e_valid;
    int         e_lo;
    int         e_hi;
    bit         e_last;
  } vec_t;

  vec_t tbl[10];

  initial begin
    // Reset, single-bit vector, then 4'b1011 with a three-cycle stall on its first beat.
    tbl[0] = '{1'b1, 1'b0, 4'b0000, 1'b0, 1'b0, 0, 0, 1'b0};
    tbl[1] = '{1'b0, 1'b1, 4'b0100, 1'b1, 1'b1, 2, 2, 1'b1};
    tbl[2] = '{1'b0, 1'b0, 4'b0000, 1'b1, 1'b0, 0, 0, 1'b0};
    tbl[3] = '{1'b0, 1'b1, 4'b1011, 1'b0, 1'b1, 0, 3, 1'b0};
    tbl[4] = '{1'b0, 1'b0, 4'b0000, 1'b0, 1'b1, 0, 3, 1'b0};
    tbl[5] = '{1'b0, 1'b0, 4'b0000, 1'b0, 1'b1, 0, 3, 1'b0};
    tbl[6] = '{1'b0, 1'b0, 4'b0000, 1'b0, 1'b1, 0, 3, 1'b0};
    tbl[7] = '{1'b0, 1'b0, 4'b0000, 1'b1, 1'b1, 1, 1, 1'b0};
    tbl[8] = '{1'b0, 1'b0, 4'b0000, 1'b1, 1'b1, 3, 0, 1'b1};
    tbl[9] = '{1'b0, 1'b0, 4'b0000, 1'b1, 1'b0, 0, 0, 1'b0};

    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      rst = tbl[i].rs; in_valid = tbl[i].iv; req = tbl[i].r; out_ready = tbl[i].ordy;
      @(posedge clk);
      @(negedge clk);
      check($sformatf("tbl%0d lo out_valid", i), 32'(lo_out_valid), 32'(tbl[i].e_valid));
      check($sformatf("tbl%0d lo in_ready", i),  32'(lo_in_ready),  32'(!tbl[i].e_valid));
      check($sformatf("tbl%0d lo code", i),      32'(lo_code),      32'(tbl[i].e_lo));
      check($sformatf("tbl%0d lo last", i),      32'(lo_last),      32'(tbl[i].e_last));
      check($sformatf("tbl%0d lo empty", i),     32'(lo_empty),     32'd0);
      check($sformatf("tbl%0d hi out_valid", i), 32'(hi_out_valid), 32'(tbl[i].e_valid));
      check($sformatf("tbl%0d hi code", i),      32'(hi_code),      32'(tbl[i].e_hi));
      check($sformatf("tbl%0d hi last", i),      32'(hi_last),      32'(tbl[i].e_last));
    end

    // New request during EMIT of 4'b1111 must be ignored.
    cycle("ign0", 1'b0, 1'b1, 4'b1111, 1'b1);
    cycle("ign1", 1'b0, 1'b1, 4'b0001, 1'b1);
    cycle("ign2", 1'b0, 1'b1, 4'b0001, 1'b1);
    cycle("ign3", 1'b0, 1'b1, 4'b0001, 1'b1);
    cycle("ign4", 1'b0, 1'b0, 4'b0000, 1'b1);
    cycle("ign5", 1'b0, 1'b0, 4'b0000, 1'b1);

    // Reset after the second beat discards the rest.
    cycle("rst0", 1'b0, 1'b1, 4'b1111, 1'b1);
    cycle("rst1", 1'b0, 1'b0, 4'b0000, 1'b1);
    cycle("rst2", 1'b0, 1'b0, 4'b0000, 1'b1);
    cycle("rst3", 1'b1, 1'b0, 4'b0000, 1'b1);
    check("rst3 lo valid dropped", 32'(lo_out_valid), 32'd0);
    cycle("rst4", 1'b0, 1'b0, 4'b0000, 1'b1);
    cycle("rst5", 1'b0, 1'b0, 4'b0000, 1'b1);

    // All-zero vector, with and without back-pressure.
    cycle("zero0", 1'b0, 1'b1, 4'b0000, 1'b1);
    cycle("zero1", 1'b0, 1'b0, 4'b0000, 1'b1);
    cycle("zero2", 1'b0, 1'b1, 4'b0000, 1'b0);
    cycle("zero3", 1'b0, 1'b0, 4'b0000, 1'b0);
    cycle("zero4", 1'b0, 1'b0, 4'b0000, 1'b1);
    cycle("zero5", 1'b0, 1'b0, 4'b0000, 1'b1);

    // Random traffic against the reference model.
    for (int i = 0; i < 400; i++) begin
      cycle($sformatf("rnd%0d", i), ($urandom_range(0, 59) == 0), 1'($urandom),
            4'($urandom), ($urandom_range(0, 3) != 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
